// File: rtl/fetch_stage_if.sv
// fetch_stage_if: memory, hazard, redirect and IF/ID signals of the fetch stage
//   master: fetch_stage side (drives imemREN/imemaddr and the IF/ID outputs)
//   slave : environment side (memory, hazard unit, branch resolution, decode)
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  modport master (
    input  ihit, imemload, stall, redirect_en, redirect_pc,
    output imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc4, opcode, funct
  );
  modport slave (
    output ihit, imemload, stall, redirect_en, redirect_pc,
    input  imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc4, opcode, funct
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC, IF/ID latch, one-entry skid buffer and HALT stop
//   CLK, nRST    : clock, asynchronous active-low reset
//   bus (master) : ihit/imemload in, imemREN/imemaddr out, stall/redirect in, IF/ID + opcode/funct out
//   fetch_count, stall_count : performance counters, present only when FETCH_PERF_EN is defined
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         nRST,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  stall_count
`endif
);
  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] SKID   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, pc4;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d, skid_pc4_q, skid_pc4_d;
  logic        load;
  logic [31:0] load_instr, load_pc4;
  always_comb begin
    pc4          = pc_q + 32'd4;
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    load         = 1'b0;
    load_instr   = bus.imemload;
    load_pc4     = pc4;
    if (bus.redirect_en) begin
      pc_d         = {bus.redirect_pc[31:2], 2'b00};
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
      skid_instr_d = '0;
      skid_pc4_d   = '0;
      state_d      = FETCH;
    end else if (state_q == FETCH) begin
      if (bus.ihit) begin
        pc_d = pc4;
        if (bus.stall) begin
          skid_instr_d = bus.imemload;
          skid_pc4_d   = pc4;
          state_d      = SKID;
        end else begin
          load = 1'b1;
        end
      end else if (!bus.stall) begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = '0;
        ifid_pc4_d   = '0;
      end
    end else if (state_q == SKID && !bus.stall) begin
      load       = 1'b1;
      load_instr = skid_instr_q;
      load_pc4   = skid_pc4_q;
      state_d    = FETCH;
    end
    // HALT is recognised on the word actually entering IF/ID, whether fresh or from the skid
    if (load) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = load_instr;
      ifid_pc4_d   = load_pc4;
      state_d      = (load_instr[31:26] == 6'h3F) ? HALTED : state_d;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, stall_count_q;
  // a redirect or bubble cycle outside HALTED also counts as a cycle with no advance
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_q + {31'd0, load};
      stall_count_q <= stall_count_q + {31'd0, (state_q != HALTED) && !load};
    end
  end
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif
  assign bus.imemREN    = (state_q == FETCH);
  assign bus.imemaddr   = pc_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc4   = ifid_pc4_q;
  assign bus.opcode     = ifid_instr_q[31:26];
  assign bus.funct      = ifid_instr_q[5:0];
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS datapath: owns the PC, drives instruction-memory requests, and holds the IF/ID latch whose opcode/funct fields feed the control unit in decode. Absorbs memory wait states, downstream stalls via a one-entry skid buffer, and control-flow redirects from later stages. Stops fetching once a HALT instruction is latched.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory returned imemload for imemaddr this cycle
- imemload  in  32  instruction word from memory
- imemREN  out  1  instruction read enable
- imemaddr  out  32  fetch address (current PC)
- stall  in  1  hazard unit: decode cannot accept a new instruction
- redirect_en  in  1  branch/jump resolved taken; flush and refetch
- redirect_pc  in  32  redirect target
- ifid_valid  out  1  IF/ID latch holds a live instruction
- ifid_instr  out  32  latched instruction
- ifid_pc4  out  32  latched PC+4
- opcode  out  6  ifid_instr[31:26], to control unit
- funct  out  6  ifid_instr[5:0], to control unit
- fetch_count, stall_count  out  32 each  only with FETCH_PERF_EN

## Operation
- States: FETCH, SKID, HALTED. Reset: FETCH, PC=PC_INIT, ifid_valid=0, ifid_instr=0, ifid_pc4=0, skid empty, counters 0.
- imemaddr = PC always; imemREN = 1 in FETCH only, 0 in SKID and HALTED.
- Priority per cycle: redirect_en > stall > normal.
- redirect_en (any state): PC ← {redirect_pc[31:2],2'b00}; IF/ID ← bubble (valid=0, instr=0, pc4=0); skid discarded; state → FETCH. Any ihit that cycle is dropped.
- FETCH, ihit, !stall: IF/ID ← {1, imemload, PC+4}; PC ← PC+4.
- FETCH, ihit, stall: IF/ID holds; skid ← {imemload, PC+4}; PC ← PC+4; → SKID.
- FETCH, !ihit, !stall: IF/ID ← bubble; PC holds.
- FETCH, !ihit, stall: everything holds.
- SKID, stall: hold. SKID, !stall: IF/ID ← {1, skid}; → FETCH (memory request resumes next cycle).
- HALT detection: when the word written into IF/ID has opcode 6'b111111, state → HALTED (same edge). HALTED: PC and IF/ID hold; only redirect_en or reset leaves it.
- Bubble instruction is 32'h0 (sll $0,$0,0): opcode/funct decode as RTYPE/SLL with no side effects because valid=0.
- PC arithmetic is 32-bit modulo; PC 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Fetch-to-decode latency 1 cycle: word on imemload with ihit at edge N appears on ifid_instr after edge N.
- Redirect penalty: target fetch address on imemaddr the cycle after redirect_en; one bubble minimum.
- Skid release: buffered instruction enters IF/ID on the first edge with stall low; no instruction lost or duplicated.
- opcode/funct are combinational slices of the IF/ID register; no added latency.
- nRST assertion mid-operation clears all state asynchronously, including an occupied skid.

## Configuration
- FETCH_PERF_EN defined: fetch_count increments on every edge where a valid instruction enters IF/ID; stall_count increments on every edge not in HALTED where no instruction advances into IF/ID (memory wait, stall, or SKID hold); both wrap at 2^32 and reset to 0.
- Not defined: both ports and counters are absent; behaviour otherwise identical.

## Test plan
- Reset, ihit=1 every cycle, imemload = 32'h2001_0005 then 32'h2002_0007: imemaddr 0,4,8; ifid_pc4 4 then 8; ifid_valid rises one cycle after first ihit.
- ihit low 3 cycles at PC=8: imemaddr stays 8, three bubbles (ifid_valid=0), then resumes at 12.
- stall high 2 cycles with ihit=1 at PC=4: skid captures word at 4, imemREN=0, PC=8; on release IF/ID gets word at 4 with pc4=8, next fetch from 8.
- redirect_en with redirect_pc=32'h0000_0103 in same cycle as ihit and stall: PC=0x100, skid discarded, IF/ID bubble, state FETCH.
- Fetch 32'hFC00_0000 at PC=0x10: ifid_valid=1, opcode=6'h3F, imemREN=0 thereafter, PC stays 0x14; later redirect_en to 0x40 resumes fetch at 0x40.
- With FETCH_PERF_EN: 5 fetches plus 2 stall cycles → fetch_count=5, stall_count=2.
